// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//
// Sequences stalls, bubbles, flushes and cache freezes for the 5-stage MIPS
// pipeline. Covers the hazards the EX- and ID-stage forwarding units cannot
// resolve: load-use, branch/JR/JALR operands still being produced by an ALU
// op in EX or a load in EX/MEM, and I-/D-cache miss freezes.
//
// Handshake/enable semantics: every *_write output is a plain register
// enable for the next rising clk edge; IdEx_bubble and IfId_flush replace
// the loaded contents with a NOP on that same edge. All outputs are
// combinational from the current state and inputs (Mealy), and all are
// forced low while rst_n is low.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   IfId_*, IfIdRs, IfIdRt     decoded fields of the instruction in ID
//   IdExRd, IdEx_RegWrite,
//   IdEx_MemRead               destination/control of the instruction in EX
//   ExMemRd, ExMem_MemRead     destination/control of the instruction in MEM
//   Branch_taken, Jump         ID-stage control-flow redirect requests
//   ICache_stall, DCache_stall cache busy -> whole pipeline freezes
//   PC_write .. MemWb_write    pipeline register enables
//   IdEx_bubble, IfId_flush    NOP insertion into ID/EX and IF/ID
//   stall_cnt, freeze_cnt,
//   flush_cnt                  saturating performance counters
module hazard_stall_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       IfId_Opcode,
    input  logic [3:0]       IfId_Funct4b,
    input  logic [4:0]       IfIdRs,
    input  logic [4:0]       IfIdRt,
    input  logic             IfId_UseRs,
    input  logic             IfId_UseRt,
    input  logic [4:0]       IdExRd,
    input  logic             IdEx_RegWrite,
    input  logic             IdEx_MemRead,
    input  logic [4:0]       ExMemRd,
    input  logic             ExMem_MemRead,
    input  logic             Branch_taken,
    input  logic             Jump,
    input  logic             ICache_stall,
    input  logic             DCache_stall,
    output logic             PC_write,
    output logic             IfId_write,
    output logic             IfId_flush,
    output logic             IdEx_write,
    output logic             IdEx_bubble,
    output logic             ExMem_write,
    output logic             MemWb_write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The registered state records the bubbles still owed *after* the
    // current cycle. A hazard is detected in RUN and its first bubble is
    // issued in that same cycle, so a two-bubble hazard (load feeding a
    // branch) leaves one bubble owed (S1) and a one-bubble hazard returns
    // straight to RUN, where the ID instruction is re-evaluated.
    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_S1  = 2'd1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic is_br;
    logic use_rs, use_rt;
    logic match_ex, match_mem;
    logic lu2, lu1, ba1, bm1;
    logic in_run, hazard, freeze;
    logic stall, flush, advance, pipe_en;

    always_comb begin
        // BEQ, BNE, JR, JALR compare/consume their operands in ID.
        is_br = (IfId_Opcode == 6'b000100) || (IfId_Opcode == 6'b000101) ||
                ((IfId_Opcode == 6'b000000) &&
                 ((IfId_Funct4b == 4'b1000) || (IfId_Funct4b == 4'b1001)));

        // Branch-type instructions always read both fields in ID.
        use_rs = IfId_UseRs || is_br;
        use_rt = IfId_UseRt || is_br;

        match_ex  = (IdExRd != 5'd0) &&
                    ((use_rs && (IdExRd == IfIdRs)) || (use_rt && (IdExRd == IfIdRt)));
        match_mem = (ExMemRd != 5'd0) &&
                    ((use_rs && (ExMemRd == IfIdRs)) || (use_rt && (ExMemRd == IfIdRt)));

        // Priority LU2 > LU1 > BA1 > BM1 only matters for the bubble count:
        // LU2 is the sole two-bubble class, so it alone selects S1 below.
        lu2 = IdEx_MemRead && match_ex && is_br;
        lu1 = IdEx_MemRead && match_ex && !is_br;
        ba1 = is_br && IdEx_RegWrite && !IdEx_MemRead && match_ex;
        bm1 = is_br && ExMem_MemRead && match_mem;

        freeze = ICache_stall || DCache_stall;
        in_run = (state_q == ST_RUN);
        hazard = in_run && (lu2 || lu1 || ba1 || bm1);

        // Freeze overrides everything; redirects are ignored while stalled
        // because the branch operands are not valid yet.
        stall   = rst_n && !freeze && (!in_run || hazard);
        flush   = rst_n && !freeze && in_run && !hazard && (Branch_taken || Jump);
        advance = rst_n && !freeze && !stall;
        pipe_en = rst_n && !freeze;

        PC_write    = advance;
        IfId_write  = advance;
        IfId_flush  = flush;
        IdEx_write  = pipe_en;
        IdEx_bubble = stall;
        ExMem_write = pipe_en;
        MemWb_write = pipe_en;

        state_d = state_q;
        if (!freeze) begin
            case (state_q)
                ST_RUN:  state_d = lu2 ? ST_S1 : ST_RUN;
                ST_S1:   state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end

        stall_cnt_d  = stall_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (freeze && (freeze_cnt_q != {CNT_W{1'b1}})) begin
            freeze_cnt_d = freeze_cnt_q + CNT_ONE;
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  logic        clk;
  logic        rst_n;
  logic [5:0]  IfId_Opcode;
  logic [3:0]  IfId_Funct4b;
  logic [4:0]  IfIdRs, IfIdRt;
  logic        IfId_UseRs, IfId_UseRt;
  logic [4:0]  IdExRd;
  logic        IdEx_RegWrite, IdEx_MemRead;
  logic [4:0]  ExMemRd;
  logic        ExMem_MemRead;
  logic        Branch_taken, Jump;
  logic        ICache_stall, DCache_stall;

  logic        PC_write, IfId_write, IfId_flush, IdEx_write, IdEx_bubble;
  logic        ExMem_write, MemWb_write;
  logic [31:0] stall_cnt, freeze_cnt, flush_cnt;

  logic        u4_pc, u4_ifid_w, u4_flush, u4_idex_w, u4_bubble, u4_exmem_w, u4_memwb_w;
  logic [3:0]  u4_stall_cnt, u4_freeze_cnt, u4_flush_cnt;

  hazard_stall_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .IfId_Opcode(IfId_Opcode), .IfId_Funct4b(IfId_Funct4b),
    .IfIdRs(IfIdRs), .IfIdRt(IfIdRt), .IfId_UseRs(IfId_UseRs), .IfId_UseRt(IfId_UseRt),
    .IdExRd(IdExRd), .IdEx_RegWrite(IdEx_RegWrite), .IdEx_MemRead(IdEx_MemRead),
    .ExMemRd(ExMemRd), .ExMem_MemRead(ExMem_MemRead),
    .Branch_taken(Branch_taken), .Jump(Jump),
    .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
    .PC_write(PC_write), .IfId_write(IfId_write), .IfId_flush(IfId_flush),
    .IdEx_write(IdEx_write), .IdEx_bubble(IdEx_bubble),
    .ExMem_write(ExMem_write), .MemWb_write(MemWb_write),
    .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
  );

  hazard_stall_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .IfId_Opcode(IfId_Opcode), .IfId_Funct4b(IfId_Funct4b),
    .IfIdRs(IfIdRs), .IfIdRt(IfIdRt), .IfId_UseRs(IfId_UseRs), .IfId_UseRt(IfId_UseRt),
    .IdExRd(IdExRd), .IdEx_RegWrite(IdEx_RegWrite), .IdEx_MemRead(IdEx_MemRead),
    .ExMemRd(ExMemRd), .ExMem_MemRead(ExMem_MemRead),
    .Branch_taken(Branch_taken), .Jump(Jump),
    .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
    .PC_write(u4_pc), .IfId_write(u4_ifid_w), .IfId_flush(u4_flush),
    .IdEx_write(u4_idex_w), .IdEx_bubble(u4_bubble),
    .ExMem_write(u4_exmem_w), .MemWb_write(u4_memwb_w),
    .stall_cnt(u4_stall_cnt), .freeze_cnt(u4_freeze_cnt), .flush_cnt(u4_flush_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: bubbles still owed plus plain integer event counts.
  int     owed = 0, owed_n = 0;
  longint m_stall = 0, m_freeze = 0, m_flush = 0;
  bit     inc_s = 0, inc_f = 0, inc_fl = 0;

  // 0 = no hazard, otherwise number of bubbles the ID instruction needs.
  function automatic int hz_class();
    bit br, rs_used, rt_used, dep_ex, dep_mem;
    br = (IfId_Opcode == 6'b000100) || (IfId_Opcode == 6'b000101) ||
         (IfId_Opcode == 6'b000000 && (IfId_Funct4b == 4'b1000 || IfId_Funct4b == 4'b1001));
    rs_used = IfId_UseRs || br;
    rt_used = IfId_UseRt || br;
    dep_ex  = (IdExRd != 0) && ((rs_used && IdExRd == IfIdRs) || (rt_used && IdExRd == IfIdRt));
    dep_mem = (ExMemRd != 0) && ((rs_used && ExMemRd == IfIdRs) || (rt_used && ExMemRd == IfIdRt));
    if (IdEx_MemRead && dep_ex) return br ? 2 : 1;
    if (br && IdEx_RegWrite && dep_ex) return 1;
    if (br && ExMem_MemRead && dep_mem) return 1;
    return 0;
  endfunction

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  always @(negedge clk) begin
    bit e_adv, e_en, e_bub, e_fl;
    int cls;
    e_adv = 0; e_en = 0; e_bub = 0; e_fl = 0;
    inc_s = 0; inc_f = 0; inc_fl = 0;
    owed_n = owed;
    cls = hz_class();
    if (!rst_n) begin
      owed_n = 0;
    end else if (ICache_stall || DCache_stall) begin
      inc_f = 1;
    end else if (owed > 0) begin
      e_en = 1; e_bub = 1; inc_s = 1; owed_n = owed - 1;
    end else if (cls > 0) begin
      e_en = 1; e_bub = 1; inc_s = 1; owed_n = cls - 1;
    end else begin
      e_en = 1; e_adv = 1; e_fl = Branch_taken || Jump; inc_fl = e_fl;
    end
    chk("PC_write", PC_write, e_adv);
    chk("IfId_write", IfId_write, e_adv);
    chk("IfId_flush", IfId_flush, e_fl);
    chk("IdEx_write", IdEx_write, e_en);
    chk("IdEx_bubble", IdEx_bubble, e_bub);
    chk("ExMem_write", ExMem_write, e_en);
    chk("MemWb_write", MemWb_write, e_en);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("freeze_cnt", freeze_cnt, m_freeze);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("w4 IdEx_bubble", u4_bubble, e_bub);
    chk("w4 stall_cnt", u4_stall_cnt, sat4(m_stall));
    chk("w4 freeze_cnt", u4_freeze_cnt, sat4(m_freeze));
    chk("w4 flush_cnt", u4_flush_cnt, sat4(m_flush));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owed = 0; m_stall = 0; m_freeze = 0; m_flush = 0;
    end else begin
      owed = owed_n;
      m_stall  = m_stall + inc_s;
      m_freeze = m_freeze + inc_f;
      m_flush  = m_flush + inc_fl;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr();
    IfId_Opcode = 6'd0; IfId_Funct4b = 4'd0; IfIdRs = 5'd0; IfIdRt = 5'd0;
    IfId_UseRs = 1'b0; IfId_UseRt = 1'b0;
    IdExRd = 5'd0; IdEx_RegWrite = 1'b0; IdEx_MemRead = 1'b0;
    ExMemRd = 5'd0; ExMem_MemRead = 1'b0;
    Branch_taken = 1'b0; Jump = 1'b0; ICache_stall = 1'b0; DCache_stall = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lu2_setup(); // LW $3 in EX, BEQ $3,$6 in ID
    clr();
    IfId_Opcode = 6'b000100; IfIdRs = 5'd3; IfIdRt = 5'd6;
    IdExRd = 5'd3; IdEx_MemRead = 1'b1; IdEx_RegWrite = 1'b1;
  endtask

  task automatic lu1_setup(); // LW $2 in EX, ADD using $2 in ID
    clr();
    IfIdRs = 5'd2; IfIdRt = 5'd9; IfId_UseRs = 1'b1; IfId_UseRt = 1'b1;
    IdExRd = 5'd2; IdEx_MemRead = 1'b1; IdEx_RegWrite = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    chk("reset PC_write", PC_write, 0);
    chk("reset MemWb_write", MemWb_write, 0);
    chk("reset stall_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("run PC_write", PC_write, 1);
    step(1);

    // load-use, one bubble
    lu1_setup();
    #1 chk("lu1 bubble", IdEx_bubble, 1);
    chk("lu1 PC_write", PC_write, 0);
    step(1);
    chk("lu1 stall_cnt", stall_cnt, 1);
    clr(); IfIdRs = 5'd2; IfId_UseRs = 1'b1;
    #1 chk("lu1 resume", PC_write, 1);
    step(1);

    // load feeding BEQ: two bubbles, then taken branch flushes
    lu2_setup();
    step(1);
    IdExRd = 5'd0; IdEx_MemRead = 1'b0; IdEx_RegWrite = 1'b0;
    ExMemRd = 5'd3; ExMem_MemRead = 1'b1;
    #1 chk("lu2 second bubble", IdEx_bubble, 1);
    step(1);
    clr(); IfId_Opcode = 6'b000100; IfIdRs = 5'd3; Branch_taken = 1'b1;
    #1 chk("lu2 flush", IfId_flush, 1);
    step(1);
    chk("lu2 stall_cnt", stall_cnt, 3);
    chk("lu2 flush_cnt", flush_cnt, 1);
    clr(); step(1);

    // ADD rd=4 in EX, JR $4 in ID: one bubble, then jump flushes
    IfId_Funct4b = 4'b1000; IfIdRs = 5'd4; IdExRd = 5'd4; IdEx_RegWrite = 1'b1;
    step(1);
    IdExRd = 5'd0; IdEx_RegWrite = 1'b0; Jump = 1'b1;
    step(1);
    // LW rd=5 in MEM, BNE rt=5 in ID: one bubble
    clr(); IfId_Opcode = 6'b000101; IfIdRs = 5'd8; IfIdRt = 5'd5;
    ExMemRd = 5'd5; ExMem_MemRead = 1'b1;
    step(1);
    chk("bm1 stall_cnt", stall_cnt, 5);
    // dependences through $0 never stall
    clr(); IfId_UseRs = 1'b1; IdEx_MemRead = 1'b1;
    #1 chk("rd0 no bubble", IdEx_bubble, 0);
    step(1);
    clr(); IfId_Opcode = 6'b000101; ExMem_MemRead = 1'b1;
    step(1);
    // matching rs not used by a non-branch op
    clr(); IfIdRs = 5'd7; IdExRd = 5'd7; IdEx_MemRead = 1'b1;
    #1 chk("unused rs no bubble", IdEx_bubble, 0);
    step(1);
    chk("no-stall stall_cnt", stall_cnt, 5);
    chk("jr flush_cnt", flush_cnt, 2);
    // LU2 and BM1 at once: LU2 wins, two bubbles
    lu2_setup(); ExMemRd = 5'd6; ExMem_MemRead = 1'b1;
    step(2);
    clr(); step(1);

    // freeze while the hazard is present: no entry, then two bubbles
    lu2_setup(); DCache_stall = 1'b1; Branch_taken = 1'b1;
    #1 chk("freeze PC_write", PC_write, 0);
    chk("freeze ExMem_write", ExMem_write, 0);
    chk("freeze flush", IfId_flush, 0);
    step(3);
    chk("freeze_cnt", freeze_cnt, 3);
    DCache_stall = 1'b0; Branch_taken = 1'b0;
    step(2);
    chk("post-freeze stall_cnt", stall_cnt, 9);
    clr(); step(1);
    // freeze in the middle of a two-bubble stall
    lu2_setup(); step(1);
    ICache_stall = 1'b1; step(2);
    ICache_stall = 1'b0;
    #1 chk("resumed bubble", IdEx_bubble, 1);
    step(1);
    clr();
    #1 chk("stall done", IdEx_bubble, 0);
    step(1);

    // saturation of the 4-bit counter
    lu1_setup(); step(16);
    chk("w4 stall saturated", u4_stall_cnt, 4'hF);
    chk("stall_cnt 27", stall_cnt, 27);
    clr(); step(1);

    // async reset while one bubble is still owed
    lu2_setup(); step(1);
    #2 rst_n = 1'b0;
    #1 chk("async rst IdEx_write", IdEx_write, 0);
    chk("async rst bubble", IdEx_bubble, 0);
    chk("async rst stall_cnt", stall_cnt, 0);
    chk("async rst freeze_cnt", freeze_cnt, 0);
    @(posedge clk); #1;
    clr(); rst_n = 1'b1;
    #1 chk("post-rst PC_write", PC_write, 1);
    chk("post-rst bubble", IdEx_bubble, 0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
